// File: rtl/spi_pkt_mem_writer.sv
// Packet writer: buffers the data words of one write packet and stores them to
// memory over a request/grant/rvalid port, one outstanding write at a time.
//
// state | meaning
// IDLE  | waiting for a packet header
// FILL  | packet open, FIFO empty, waiting for a data word
// REQ   | write request on the bus, waiting for grant
// RSP   | write granted, waiting for its response
// DONE  | one-cycle completion pulse, then back to IDLE
module spi_pkt_mem_writer #(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_sys,
  input  logic             rst_sys_n,
  input  logic             hdr_valid,
  input  logic [WIDTH-1:0] hdr_addr,
  input  logic [WIDTH-1:0] hdr_size,
  input  logic             word_valid,
  input  logic [WIDTH-1:0] word_data,
  output logic             word_ready,
  output logic             busy,
  output logic             mem_req_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  input  logic             mem_err_i,
  output logic             mem_we_o,
  output logic [3:0]       mem_be_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  output logic             pack_done,
  output logic             pack_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_REQ,
    S_RSP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] size_q, size_d;
  logic [WIDTH-1:0] in_cnt_q, in_cnt_d;
  logic [WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic             err_q, err_d;
  logic             req_q, req_d;
  logic [WIDTH-1:0] maddr_q, maddr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] fifo_mem [FIFO_DEPTH];

  logic             fifo_full, fifo_empty;
  logic             accepting, in_room;
  logic             push, pop, overflow;
  logic [WIDTH-1:0] fifo_head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr_q[AW-1:0]];

  assign accepting  = (state_q == S_FILL) || (state_q == S_REQ) || (state_q == S_RSP);
  assign in_room    = (in_cnt_q != size_q);
  assign word_ready = accepting && !fifo_full && in_room;
  assign push       = word_valid && word_ready;
  assign overflow   = word_valid && accepting && fifo_full && in_room;
  assign pop        = (state_q == S_REQ) && mem_gnt_i;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    in_cnt_d  = in_cnt_q + {{(WIDTH-1){1'b0}}, push};
    out_cnt_d = out_cnt_q;
    err_d     = err_q | overflow;
    req_d     = req_q;
    maddr_d   = maddr_q;
    wdata_d   = wdata_q;
    wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};

    unique case (state_q)
      S_IDLE: begin
        if (hdr_valid) begin
          addr_d    = hdr_addr & ~WIDTH'(3);
          size_d    = hdr_size;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          err_d     = 1'b0;
          rd_ptr_d  = wr_ptr_q;
          state_d   = (hdr_size == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        if (!fifo_empty) begin
          req_d   = 1'b1;
          maddr_d = addr_q;
          wdata_d = fifo_head;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt_i) begin
          req_d   = 1'b0;
          addr_d  = addr_q + WIDTH'(4);
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (mem_rvalid_i) begin
          if (mem_err_i) err_d = 1'b1;
          out_cnt_d = out_cnt_q + WIDTH'(1);
          if (out_cnt_q + WIDTH'(1) == size_q) begin
            state_d = S_DONE;
          end else if (!fifo_empty) begin
            // head was already popped at grant, so this is the next word
            req_d   = 1'b1;
            maddr_d = addr_q;
            wdata_d = fifo_head;
            state_d = S_REQ;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
      req_q     <= 1'b0;
      maddr_q   <= '0;
      wdata_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_d;
      req_q     <= req_d;
      maddr_q   <= maddr_d;
      wdata_q   <= wdata_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // storage needs no reset; emptiness is carried by the pointers
  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= word_data;
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = req_q;
  assign mem_be_o    = {4{req_q}};
  assign mem_addr_o  = maddr_q;
  assign mem_wdata_o = wdata_q;
  assign busy        = (state_q != S_IDLE);
  assign pack_done   = (state_q == S_DONE);
  assign pack_err    = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_spi_pkt_mem_writer.sv
// Bench for spi_pkt_mem_writer: directed and random packets against a bus
// responder, compared with addresses/data derived from the packet parameters.
module tb_spi_pkt_mem_writer;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n = 1'b0;
  logic        hdr_valid = 1'b0;
  logic [31:0] hdr_addr = '0;
  logic [31:0] hdr_size = '0;
  logic        word_valid = 1'b0;
  logic [31:0] word_data = '0;
  logic        word_ready;
  logic        busy;
  logic        mem_req_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic        mem_err_i = 1'b0;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        pack_done;
  logic        pack_err;

  spi_pkt_mem_writer #(.WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
    .hdr_valid(hdr_valid), .hdr_addr(hdr_addr), .hdr_size(hdr_size),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .busy(busy),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_err_i(mem_err_i), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .pack_done(pack_done), .pack_err(pack_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        we;
  } wr_t;

  wr_t  obs_q[$];
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  logic last_err = 1'b0;
  int   proto_err = 0;
  int   req_seen = 0;
  int   gnt_delay = 0;
  int   rsp_delay = 1;
  int   err_idx = -1;
  int   rsp_idx = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus responder and protocol monitor; everything sampled at the falling edge.
  initial begin : responder
    int wait_cnt;
    int rsp_cnt;
    bit waiting;
    logic [31:0] held_a, held_d;
    wait_cnt = 0; rsp_cnt = 0; waiting = 0; held_a = '0; held_d = '0;
    forever begin
      @(negedge clk_sys);
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_err_i = 1'($urandom_range(0, 1));
      if (!rst_sys_n) begin
        wait_cnt = 0; rsp_cnt = 0; waiting = 0;
      end else begin
        if (pack_done) begin done_cnt++; last_err = pack_err; end
        if (pack_err && !pack_done) proto_err++;
        if (!mem_req_o && (mem_we_o || mem_be_o != 4'h0)) proto_err++;
        if (waiting && (!mem_req_o || mem_addr_o !== held_a || mem_wdata_o !== held_d))
          proto_err++;
        waiting = 0;
        if (mem_req_o) req_seen++;
        if (rsp_cnt > 0) begin
          rsp_cnt--;
          if (rsp_cnt == 0) begin
            mem_rvalid_i = 1'b1;
            mem_err_i = (rsp_idx == err_idx);
            rsp_idx++;
          end
        end else if (mem_req_o) begin
          if (wait_cnt >= gnt_delay) begin
            mem_gnt_i = 1'b1;
            obs_q.push_back('{addr: mem_addr_o, data: mem_wdata_o, be: mem_be_o, we: mem_we_o});
            rsp_cnt = rsp_delay;
            wait_cnt = 0;
          end else begin
            wait_cnt++;
            waiting = 1;
            held_a = mem_addr_o;
            held_d = mem_wdata_o;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  // All driving tasks start and end just after a falling edge.
  task automatic send_hdr(input logic [31:0] a, input logic [31:0] s);
    hdr_valid = 1'b1; hdr_addr = a; hdr_size = s;
    @(negedge clk_sys);
    hdr_valid = 1'b0;
    chk("busy_after_hdr", busy, 1);
  endtask

  task automatic send_word(input logic [31:0] d);
    int n = 0;
    while (!word_ready && n < 500) begin
      @(negedge clk_sys);
      n++;
    end
    chk("ready_wait", (n < 500) ? 1 : 0, 1);
    word_valid = 1'b1; word_data = d;
    @(negedge clk_sys);
    word_valid = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int n = 0;
    while (done_cnt == prev && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic start_pkt(input int eidx, input int gd, input int rd);
    gnt_delay = gd; rsp_delay = rd; err_idx = eidx; rsp_idx = 0;
    obs_q.delete();
  endtask

  task automatic check_writes(input string tag, input logic [31:0] base,
                              input logic [31:0] words[$], input bit exp_err, input int prev);
    logic [31:0] a;
    chk({tag, "_count"}, obs_q.size(), words.size());
    a = base & 32'hFFFF_FFFC;
    foreach (words[i]) begin
      if (i < obs_q.size()) begin
        chk({tag, "_addr"}, obs_q[i].addr, a);
        chk({tag, "_data"}, obs_q[i].data, words[i]);
        chk({tag, "_be"}, obs_q[i].be, 4'hF);
        chk({tag, "_we"}, obs_q[i].we, 1);
      end
      a = a + 32'd4;
    end
    chk({tag, "_done"}, done_cnt, prev + 1);
    chk({tag, "_err"}, last_err, exp_err);
  endtask

  task automatic run_pkt(input string tag, input logic [31:0] base, input int size,
                         input int eidx, input int gd, input int rd, input int max_gap);
    logic [31:0] words[$];
    logic [31:0] d;
    int prev;
    start_pkt(eidx, gd, rd);
    prev = done_cnt;
    send_hdr(base, size);
    for (int i = 0; i < size; i++) begin
      d = $urandom;
      words.push_back(d);
      send_word(d);
      repeat ($urandom_range(0, max_gap)) @(negedge clk_sys);
    end
    wait_done(prev);
    check_writes(tag, base, words, (eidx >= 0 && eidx < size), prev);
  endtask

  initial begin : main
    logic [31:0] words[$];
    logic [31:0] d;
    logic [31:0] base;
    int prev, rs, n, sz, eidx;

    repeat (3) @(negedge clk_sys);
    chk("rst_req", mem_req_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_be", mem_be_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", word_ready, 0);
    chk("rst_done", pack_done, 0);
    chk("rst_err", pack_err, 0);
    rst_sys_n = 1'b1;
    @(negedge clk_sys);

    // word in IDLE is dropped
    chk("idle_ready", word_ready, 0);
    word_valid = 1'b1; word_data = 32'hDEAD_BEEF;
    @(negedge clk_sys);
    word_valid = 1'b0;
    chk("idle_busy", busy, 0);

    // basic packet with unaligned base; request appears 2 cycles after first push
    start_pkt(-1, 0, 1);
    prev = done_cnt;
    words.delete();
    send_hdr(32'h0000_1003, 3);
    for (int i = 0; i < 3; i++) begin
      chk("latency_req", mem_req_o, (i == 2) ? 1 : 0);
      d = $urandom;
      words.push_back(d);
      send_word(d);
    end
    wait_done(prev);
    check_writes("basic", 32'h0000_1000, words, 0, prev);

    // zero-length packet
    prev = done_cnt;
    rs = req_seen;
    send_hdr(32'h0000_3000, 0);
    chk("zero_done", pack_done, 1);
    chk("zero_perr", pack_err, 0);
    @(negedge clk_sys);
    chk("zero_done_end", pack_done, 0);
    chk("zero_idle", busy, 0);
    repeat (3) @(negedge clk_sys);
    chk("zero_no_req", req_seen, rs);
    chk("zero_done_cnt", done_cnt, prev + 1);

    // burst ignoring word_ready while grant is held off: words 5 and 6 dropped
    start_pkt(-1, 10, 1);
    prev = done_cnt;
    words.delete();
    base = $urandom;
    send_hdr(base, 6);
    for (int i = 0; i < 6; i++) begin
      chk("burst_ready", word_ready, (i < 4) ? 1 : 0);
      d = $urandom;
      if (i < 4) words.push_back(d);
      word_valid = 1'b1; word_data = d;
      @(negedge clk_sys);
    end
    word_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d = $urandom;
      words.push_back(d);
      send_word(d);
    end
    wait_done(prev);
    check_writes("overflow", base, words, 1, prev);

    run_pkt("honour", $urandom, 6, -1, 10, 1, 0);

    // error on second response; a header while busy must be ignored
    start_pkt(1, 0, 1);
    prev = done_cnt;
    words.delete();
    send_hdr(32'h0000_4000, 2);
    hdr_valid = 1'b1; hdr_addr = 32'h0000_5000; hdr_size = 0;
    @(negedge clk_sys);
    hdr_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d = $urandom;
      words.push_back(d);
      send_word(d);
    end
    wait_done(prev);
    check_writes("bus_err", 32'h0000_4000, words, 1, prev);

    run_pkt("wrap", 32'hFFFF_FFFC, 2, -1, 0, 1, 0);

    for (int p = 0; p < 8; p++) begin
      sz = $urandom_range(1, 9);
      eidx = ($urandom_range(0, 2) == 0) ? $urandom_range(0, sz - 1) : -1;
      run_pkt("rand", $urandom, sz, eidx, $urandom_range(0, 3), $urandom_range(1, 3), 2);
    end

    // reset while waiting for a response
    start_pkt(-1, 0, 8);
    prev = done_cnt;
    send_hdr(32'h0000_2000, 2);
    send_word($urandom);
    send_word($urandom);
    n = 0;
    while (obs_q.size() == 0 && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    @(negedge clk_sys);
    chk("rsp_busy", busy, 1);
    chk("rsp_req", mem_req_o, 0);
    #2 rst_sys_n = 1'b0;
    #1;
    chk("mid_rst_req", mem_req_o, 0);
    chk("mid_rst_we", mem_we_o, 0);
    chk("mid_rst_be", mem_be_o, 0);
    chk("mid_rst_addr", mem_addr_o, 0);
    chk("mid_rst_wdata", mem_wdata_o, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", word_ready, 0);
    chk("mid_rst_done", pack_done, 0);
    chk("mid_rst_err", pack_err, 0);
    repeat (2) @(negedge clk_sys);
    rst_sys_n = 1'b1;
    repeat (12) @(negedge clk_sys);
    chk("abort_no_done", done_cnt, prev);
    run_pkt("post_reset", 32'h0000_6008, 3, -1, 0, 1, 1);

    chk("protocol", proto_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_pkt_mem_writer.md
Name: spi_pkt_mem_writer

Overview:
Downstream stage of the SPI command decoder. It takes one write-packet header (base address, word count) and the stream of data words that follows. It buffers the words in a small FIFO and writes them to system memory over an OBI-style request/grant/rvalid data port, one outstanding transaction at a time. At the end of the packet it pulses pack_done, which returns the decoder to its idle state.

Parameters:
WIDTH, 32, data/address/size width in bits
FIFO_DEPTH, 4, data word buffer entries (power of two, >=2)

Ports:
clk_sys  input  1  system clock
rst_sys_n  input  1  asynchronous active-low reset
hdr_valid  input  1  one-cycle pulse; hdr_addr/hdr_size valid
hdr_addr  input  WIDTH  packet base byte address
hdr_size  input  WIDTH  packet length in words
word_valid  input  1  one-cycle pulse; word_data valid
word_data  input  WIDTH  packet data word
word_ready  output  1  FIFO can accept a word this cycle
busy  output  1  packet in progress (state != IDLE)
mem_req_o  output  1  bus request
mem_gnt_i  input  1  bus grant
mem_rvalid_i  input  1  bus response valid
mem_err_i  input  1  bus error, qualified by mem_rvalid_i
mem_we_o  output  1  write enable
mem_be_o  output  4  byte enables
mem_addr_o  output  WIDTH  bus byte address
mem_wdata_o  output  WIDTH  bus write data
pack_done  output  1  one-cycle pulse: packet complete
pack_err  output  1  one-cycle pulse coincident with pack_done: packet had an error

Behaviour:
- Clock and reset: single clock clk_sys; reset rst_sys_n is asynchronous, active-low.
- Reset: all outputs 0, FIFO empty, counters 0, error flags clear, state IDLE. Reset mid-packet aborts the packet with no pack_done and drops any pending request.
- States: IDLE, FILL, REQ, RSP, DONE.
- IDLE:
  - hdr_valid captures addr = {hdr_addr[WIDTH-1:2], 2'b00} and size = hdr_size, clears in_cnt, out_cnt and the error flag, then goes to FILL.
  - If hdr_size==0 the block goes to DONE instead; no bus traffic occurs.
  - word_valid in IDLE is dropped silently.
- Header handling while busy: hdr_valid outside IDLE is ignored.
- Word acceptance (any state except IDLE/DONE):
  - word_ready = !fifo_full && (in_cnt != size).
  - word_valid && word_ready pushes word_data and increments in_cnt.
  - word_valid && fifo_full && in_cnt != size: word dropped, sticky err set (overflow).
  - word_valid && in_cnt == size: word dropped, no error.
- FILL: if FIFO non-empty, go to REQ next cycle. Latency from a push into an empty FIFO to mem_req_o high is 2 cycles.
- REQ:
  - Outputs: mem_req_o=1, mem_we_o=1, mem_be_o=4'hF, mem_addr_o=addr, mem_wdata_o=FIFO head.
  - These outputs are registered and held stable until mem_gnt_i.
  - On grant (same cycle as req high): pop FIFO, addr += 4 (wraps mod 2^WIDTH), deassert req next cycle, go to RSP.
- RSP:
  - mem_req_o=0. Wait for mem_rvalid_i.
  - On rvalid: if mem_err_i, set err. Increment out_cnt.
  - If out_cnt+1 == size, go to DONE; else go to REQ if FIFO non-empty, otherwise FILL.
  - rvalid in the grant cycle is never expected; rvalid is sampled only in RSP.
- DONE: pack_done=1 for exactly one cycle, pack_err=err in that cycle, then IDLE.
- Simultaneous push and pop in the same cycle is legal; occupancy is unchanged.
- FIFO pointers: log2(FIFO_DEPTH)+1 bits; full/empty are decided by MSB comparison.
- mem_be_o and mem_we_o are 0 whenever mem_req_o=0.
- busy=1 from the cycle after hdr_valid is accepted through the DONE cycle inclusive.

Test Plan:
- hdr(addr=0x0000_1003, size=3), words A,B,C; gnt same cycle as req, rvalid 1 cycle later -> writes to 0x1000/0x1004/0x1008 with A/B/C, be=F, one pack_done, pack_err=0.
- hdr(size=0) -> pack_done one cycle later, no mem_req_o ever.
- size=6, burst of 6 words one per cycle, gnt held low 10 cycles -> word_ready drops after 4 words, the 5th and 6th are dropped, pack_err=1. Repeat with a sender that honours word_ready -> all 6 written, pack_err=0.
- size=2, second response has mem_err_i=1 -> both writes issued, pack_done with pack_err=1.
- addr=0xFFFF_FFFC, size=2 -> second write to 0x0000_0000.
- Reset asserted while in RSP -> all outputs 0 immediately. A new packet after release completes normally, with no stale words or error carried over.
